// File: rtl/usb_rx_data_seq.sv
// USB device receive-side DATA packet sequencer.
// Opens the CRC16 receive stage after an OUT/SETUP token, validates the DATA PID,
// counts payload bytes, tracks per-endpoint data toggles and requests an ACK/NAK
// handshake from the transmitter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a token addressed to this device
// WAIT_SOP | receive stage enabled, timing out the DATA packet start
// RECV     | counting bytes after the PID until end of packet
// CHECK    | one-cycle decision: drop, NAK, duplicate ACK or commit+ACK
// HS       | holding the handshake request until TX accepts it
module usb_rx_data_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        token_out,
    input  logic [1:0]  token_ep,
    input  logic        bus_reset,
    input  logic [3:0]  clr_toggle,
    input  logic [7:0]  timeout_val,
    input  logic [10:0] max_len,
    input  logic        buf_ready,
    input  logic        rx_sop_en,
    input  logic        rx_lt_eop_en,
    input  logic        crc16_err,
    input  logic [7:0]  rx_data,
    input  logic        rx_byte_vld,
    output logic        rx_data_on,
    output logic        hs_valid,
    input  logic        hs_ready,
    output logic [3:0]  hs_pid,
    output logic        pkt_commit,
    output logic [10:0] pkt_len,
    output logic [3:0]  data_toggle,
    output logic        timeout_err,
    output logic        pid_err,
    output logic        len_err
);

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOP,
        S_RECV,
        S_CHECK,
        S_HS
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ep_q, ep_d;
    logic [7:0]  timer_q, timer_d;
    logic [10:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        rx_tgl_q, rx_tgl_d;
    logic [3:0]  hs_pid_q, hs_pid_d;
    logic [10:0] pkt_len_q, pkt_len_d;
    logic [3:0]  tgl_q, tgl_d;
    logic        rx_data_on_q, rx_data_on_d;
    logic        hs_valid_q, hs_valid_d;
    logic        commit_q, commit_d;
    logic        timeout_err_q, timeout_err_d;
    logic        pid_err_q, pid_err_d;
    logic        len_err_q, len_err_d;

    logic        pid_ok;
    logic [10:0] cnt_inc;

    assign pid_ok  = (rx_data[7:4] == ~rx_data[3:0]) &&
                     ((rx_data[3:0] == PID_DATA0) || (rx_data[3:0] == PID_DATA1));
    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        ep_d          = ep_q;
        timer_d       = timer_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        rx_tgl_d      = rx_tgl_q;
        hs_pid_d      = hs_pid_q;
        pkt_len_d     = pkt_len_q;
        tgl_d         = tgl_q;
        commit_d      = 1'b0;
        timeout_err_d = 1'b0;
        pid_err_d     = 1'b0;
        len_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (token_out) begin
                    ep_d    = token_ep;
                    timer_d = timeout_val;
                    state_d = S_WAIT_SOP;
                end
            end
            S_WAIT_SOP: begin
                if (rx_sop_en) begin
                    if (pid_ok) begin
                        rx_tgl_d = rx_data[3];
                        cnt_d    = 11'd0;
                        ovf_d    = 1'b0;
                        state_d  = S_RECV;
                    end else begin
                        pid_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (timer_q == 8'd1) begin
                    // A loaded value of 0 wraps through 255, giving 256 cycles.
                    timeout_err_d = 1'b1;
                    timer_d       = 8'd0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_RECV: begin
                if (rx_byte_vld) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc > max_len) begin
                        ovf_d = 1'b1;
                    end
                end
                if (rx_lt_eop_en) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (crc16_err || ovf_q) begin
                    len_err_d = ovf_q;
                    state_d   = S_IDLE;
                end else if (!buf_ready) begin
                    hs_pid_d = PID_NAK;
                    state_d  = S_HS;
                end else if (rx_tgl_q != tgl_q[ep_q]) begin
                    hs_pid_d = PID_ACK;
                    state_d  = S_HS;
                end else begin
                    hs_pid_d      = PID_ACK;
                    commit_d      = 1'b1;
                    pkt_len_d     = cnt_q - 11'd2;
                    tgl_d[ep_q]   = ~tgl_q[ep_q];
                    state_d       = S_HS;
                end
            end
            S_HS: begin
                if (hs_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Host-requested clear overrides a same-cycle flip.
        tgl_d = tgl_d & ~clr_toggle;

        if (bus_reset) begin
            state_d       = S_IDLE;
            tgl_d         = 4'b0000;
            hs_pid_d      = hs_pid_q;
            pkt_len_d     = pkt_len_q;
            commit_d      = 1'b0;
            timeout_err_d = 1'b0;
            pid_err_d     = 1'b0;
            len_err_d     = 1'b0;
        end

        rx_data_on_d = (state_d == S_WAIT_SOP) || (state_d == S_RECV);
        hs_valid_d   = (state_d == S_HS);
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ep_q          <= 2'd0;
            timer_q       <= 8'd0;
            cnt_q         <= 11'd0;
            ovf_q         <= 1'b0;
            rx_tgl_q      <= 1'b0;
            hs_pid_q      <= 4'd0;
            pkt_len_q     <= 11'd0;
            tgl_q         <= 4'd0;
            rx_data_on_q  <= 1'b0;
            hs_valid_q    <= 1'b0;
            commit_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            pid_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ep_q          <= ep_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            rx_tgl_q      <= rx_tgl_d;
            hs_pid_q      <= hs_pid_d;
            pkt_len_q     <= pkt_len_d;
            tgl_q         <= tgl_d;
            rx_data_on_q  <= rx_data_on_d;
            hs_valid_q    <= hs_valid_d;
            commit_q      <= commit_d;
            timeout_err_q <= timeout_err_d;
            pid_err_q     <= pid_err_d;
            len_err_q     <= len_err_d;
        end
    end

    assign rx_data_on  = rx_data_on_q;
    assign hs_valid    = hs_valid_q;
    assign hs_pid      = hs_pid_q;
    assign pkt_commit  = commit_q;
    assign pkt_len     = pkt_len_q;
    assign data_toggle = tgl_q;
    assign timeout_err = timeout_err_q;
    assign pid_err     = pid_err_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_usb_rx_data_seq.sv
// Directed bench for usb_rx_data_seq. Inputs change and outputs are sampled on
// the falling clock edge; results of a rising edge are visible at the next
// falling edge.
module tb_usb_rx_data_seq;

    logic        clk;
    logic        rst;
    logic        token_out;
    logic [1:0]  token_ep;
    logic        bus_reset;
    logic [3:0]  clr_toggle;
    logic [7:0]  timeout_val;
    logic [10:0] max_len;
    logic        buf_ready;
    logic        rx_sop_en;
    logic        rx_lt_eop_en;
    logic        crc16_err;
    logic [7:0]  rx_data;
    logic        rx_byte_vld;
    logic        rx_data_on;
    logic        hs_valid;
    logic        hs_ready;
    logic [3:0]  hs_pid;
    logic        pkt_commit;
    logic [10:0] pkt_len;
    logic [3:0]  data_toggle;
    logic        timeout_err;
    logic        pid_err;
    logic        len_err;

    int n_checks = 0;
    int n_errors = 0;

    usb_rx_data_seq dut (
        .clk          (clk),
        .rst          (rst),
        .token_out    (token_out),
        .token_ep     (token_ep),
        .bus_reset    (bus_reset),
        .clr_toggle   (clr_toggle),
        .timeout_val  (timeout_val),
        .max_len      (max_len),
        .buf_ready    (buf_ready),
        .rx_sop_en    (rx_sop_en),
        .rx_lt_eop_en (rx_lt_eop_en),
        .crc16_err    (crc16_err),
        .rx_data      (rx_data),
        .rx_byte_vld  (rx_byte_vld),
        .rx_data_on   (rx_data_on),
        .hs_valid     (hs_valid),
        .hs_ready     (hs_ready),
        .hs_pid       (hs_pid),
        .pkt_commit   (pkt_commit),
        .pkt_len      (pkt_len),
        .data_toggle  (data_toggle),
        .timeout_err  (timeout_err),
        .pid_err      (pid_err),
        .len_err      (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_token(input logic [1:0] ep);
        token_out = 1'b1;
        token_ep  = ep;
        tick();
        token_out = 1'b0;
    endtask

    task automatic send_sop(input logic [7:0] pid);
        rx_sop_en = 1'b1;
        rx_data   = pid;
        tick();
        rx_sop_en = 1'b0;
        rx_data   = 8'h00;
    endtask

    // n byte beats, the last one carrying end-of-packet.
    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            rx_byte_vld  = 1'b1;
            rx_data      = 8'(i + 1);
            rx_lt_eop_en = (i == n - 1);
            tick();
        end
        rx_byte_vld  = 1'b0;
        rx_lt_eop_en = 1'b0;
        rx_data      = 8'h00;
    endtask

    // Full packet; returns at the falling edge just after the CHECK decision.
    task automatic pkt(input logic [1:0] ep, input logic [7:0] pid, input int n,
                       input logic crc, input logic [3:0] clr);
        send_token(ep);
        send_sop(pid);
        send_bytes(n);
        chk("check_state_rx_off", 32'(rx_data_on), 0);
        crc16_err  = crc;
        clr_toggle = clr;
        tick();
        crc16_err  = 1'b0;
        clr_toggle = 4'b0000;
    endtask

    task automatic finish_hs();
        hs_ready = 1'b1;
        tick();
        hs_ready = 1'b0;
        chk("hs_release", 32'(hs_valid), 0);
    endtask

    initial begin
        rst          = 1'b1;
        token_out    = 1'b0;
        token_ep     = 2'd0;
        bus_reset    = 1'b0;
        clr_toggle   = 4'b0000;
        timeout_val  = 8'd20;
        max_len      = 11'd64;
        buf_ready    = 1'b1;
        rx_sop_en    = 1'b0;
        rx_lt_eop_en = 1'b0;
        crc16_err    = 1'b0;
        rx_data      = 8'h00;
        rx_byte_vld  = 1'b0;
        hs_ready     = 1'b0;

        repeat (2) tick();
        chk("rst_rx_data_on", 32'(rx_data_on), 0);
        chk("rst_hs_valid",   32'(hs_valid), 0);
        chk("rst_hs_pid",     32'(hs_pid), 0);
        chk("rst_commit",     32'(pkt_commit), 0);
        chk("rst_pkt_len",    32'(pkt_len), 0);
        chk("rst_toggle",     32'(data_toggle), 0);
        chk("rst_errs",       32'({timeout_err, pid_err, len_err}), 0);
        rst = 1'b0;
        tick();

        // Good DATA0 on ep1: 8 payload + 2 CRC bytes.
        send_token(2'd1);
        chk("wait_sop_rx_on", 32'(rx_data_on), 1);
        send_sop(8'hC3);
        chk("recv_rx_on", 32'(rx_data_on), 1);
        send_bytes(10);
        chk("check_state_rx_off", 32'(rx_data_on), 0);
        tick();
        chk("a_commit", 32'(pkt_commit), 1);
        chk("a_len",    32'(pkt_len), 8);
        chk("a_toggle", 32'(data_toggle), 32'h2);
        chk("a_hs",     32'(hs_valid), 1);
        chk("a_pid",    32'(hs_pid), 32'h2);
        finish_hs();
        chk("a_commit_pulse", 32'(pkt_commit), 0);

        // Same DATA0 again: duplicate, ACK without commit.
        pkt(2'd1, 8'hC3, 10, 1'b0, 4'b0000);
        chk("b_commit", 32'(pkt_commit), 0);
        chk("b_hs",     32'(hs_valid), 1);
        chk("b_pid",    32'(hs_pid), 32'h2);
        chk("b_toggle", 32'(data_toggle), 32'h2);
        chk("b_len_held", 32'(pkt_len), 8);
        finish_hs();

        // DATA1 on ep1 with 2 payload bytes flips the toggle back.
        pkt(2'd1, 8'h4B, 4, 1'b0, 4'b0000);
        chk("c_commit", 32'(pkt_commit), 1);
        chk("c_len",    32'(pkt_len), 2);
        chk("c_toggle", 32'(data_toggle), 0);
        finish_hs();

        // Timeout of 5 cycles with no SOP.
        timeout_val = 8'd5;
        send_token(2'd2);
        for (int i = 0; i < 5; i++) begin
            chk("to5_rx_on", 32'(rx_data_on), 1);
            chk("to5_no_err", 32'(timeout_err), 0);
            if (i < 4) tick();
        end
        tick();
        chk("to5_err",   32'(timeout_err), 1);
        chk("to5_rx_off", 32'(rx_data_on), 0);
        chk("to5_no_hs", 32'(hs_valid), 0);
        tick();
        chk("to5_pulse", 32'(timeout_err), 0);

        // timeout_val=0 means 256 cycles.
        timeout_val = 8'd0;
        send_token(2'd0);
        repeat (255) tick();
        chk("to256_rx_on", 32'(rx_data_on), 1);
        chk("to256_no_err", 32'(timeout_err), 0);
        tick();
        chk("to256_err", 32'(timeout_err), 1);

        // SOP coincident with expiry wins; then CRC error drops the packet.
        timeout_val = 8'd1;
        send_token(2'd0);
        send_sop(8'hC3);
        chk("sop_win_rx_on", 32'(rx_data_on), 1);
        chk("sop_win_no_to", 32'(timeout_err), 0);
        send_bytes(4);
        crc16_err = 1'b1;
        tick();
        crc16_err = 1'b0;
        chk("crc_no_hs",     32'(hs_valid), 0);
        chk("crc_no_commit", 32'(pkt_commit), 0);
        chk("crc_no_lenerr", 32'(len_err), 0);
        chk("crc_toggle",    32'(data_toggle), 0);
        timeout_val = 8'd20;

        // Bad PID check field, then a well-formed non-DATA PID.
        send_token(2'd0);
        send_sop(8'hD3);
        chk("pid_bad_chk", 32'(pid_err), 1);
        chk("pid_rx_off",  32'(rx_data_on), 0);
        chk("pid_no_hs",   32'(hs_valid), 0);
        tick();
        chk("pid_pulse", 32'(pid_err), 0);
        send_token(2'd0);
        send_sop(8'hE1);
        chk("pid_not_data", 32'(pid_err), 1);
        tick();

        // Buffer busy: NAK held while TX is not ready.
        buf_ready = 1'b0;
        pkt(2'd2, 8'hC3, 4, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            chk("nak_hs",  32'(hs_valid), 1);
            chk("nak_pid", 32'(hs_pid), 32'hA);
            chk("nak_no_commit", 32'(pkt_commit), 0);
            if (i < 2) tick();
        end
        finish_hs();
        buf_ready = 1'b1;
        chk("nak_toggle", 32'(data_toggle), 0);

        // Overlength: 8 bytes against max_len=4.
        max_len = 11'd4;
        pkt(2'd3, 8'hC3, 8, 1'b0, 4'b0000);
        chk("len_err",    32'(len_err), 1);
        chk("len_no_hs",  32'(hs_valid), 0);
        chk("len_toggle", 32'(data_toggle), 0);
        tick();
        chk("len_pulse", 32'(len_err), 0);
        // Exactly max_len bytes is accepted.
        pkt(2'd3, 8'hC3, 4, 1'b0, 4'b0000);
        chk("len_edge_commit", 32'(pkt_commit), 1);
        chk("len_edge_len",    32'(pkt_len), 2);
        chk("len_edge_toggle", 32'(data_toggle), 32'h8);
        finish_hs();
        max_len = 11'd64;

        // Clear coincident with a commit flip on ep1.
        pkt(2'd1, 8'hC3, 6, 1'b0, 4'b0010);
        chk("clr_commit", 32'(pkt_commit), 1);
        chk("clr_len",    32'(pkt_len), 4);
        chk("clr_toggle", 32'(data_toggle), 32'h8);
        finish_hs();

        // Bus reset mid-packet.
        send_token(2'd2);
        send_sop(8'hC3);
        rx_byte_vld = 1'b1;
        repeat (3) tick();
        rx_byte_vld = 1'b0;
        bus_reset = 1'b1;
        tick();
        bus_reset = 1'b0;
        chk("busrst_rx_off", 32'(rx_data_on), 0);
        chk("busrst_toggle", 32'(data_toggle), 0);
        chk("busrst_no_hs",  32'(hs_valid), 0);
        rx_lt_eop_en = 1'b1;
        tick();
        rx_lt_eop_en = 1'b0;
        tick();
        chk("busrst_eop_ignored", 32'({hs_valid, pkt_commit, rx_data_on}), 0);

        // Async reset mid-packet, then stray beats are ignored.
        send_token(2'd0);
        send_sop(8'hC3);
        rx_byte_vld = 1'b1;
        tick();
        rx_byte_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_rx_off", 32'(rx_data_on), 0);
        tick();
        rst = 1'b0;
        rx_byte_vld  = 1'b1;
        rx_lt_eop_en = 1'b1;
        tick();
        rx_byte_vld  = 1'b0;
        rx_lt_eop_en = 1'b0;
        tick();
        chk("arst_ignored", 32'({hs_valid, pkt_commit, rx_data_on}), 0);
        pkt(2'd0, 8'hC3, 3, 1'b0, 4'b0000);
        chk("arst_after_commit", 32'(pkt_commit), 1);
        chk("arst_after_len",    32'(pkt_len), 1);
        chk("arst_after_toggle", 32'(data_toggle), 32'h1);
        finish_hs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
